// File: rtl/lsu_multicycle.sv
// rtl/lsu_multicycle.sv - multicycle load/store unit with split misaligned beats and fault reporting
module lsu_multicycle #(
    parameter int XLEN        = 32,
    parameter int ADDR_WIDTH  = 9,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_rd_wr_bar,
    input  logic [2:0]            req_funct3,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_rdata,
    output logic                  rsp_fault,
    output logic                  mem_enable,
    output logic                  mem_rd_wr_bar,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [XLEN/8-1:0]     mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic [XLEN-1:0]       mem_rdata
);
    localparam int NB   = XLEN / 8;
    localparam int OFS  = $clog2(NB);
    localparam bit IS64 = (XLEN == 64);
    localparam logic [2*NB-1:0] BE_ONE = 1;

    typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_t;
    state_t state, state_nxt;

    logic                  r_load;
    logic [2:0]            r_funct3;
    logic [OFS-1:0]        r_off;
    logic [ADDR_WIDTH-1:0] r_w0;
    logic [XLEN-1:0]       r_wdata;
    logic                  r_split;
    logic                  r_fault;
    logic [XLEN-1:0]       lo_buf;

    logic [OFS-1:0] req_off;
    logic [3:0]     req_size;
    logic           req_legal;
    logic           req_misaligned;
    logic           req_split;
    logic           req_fault;
    logic           unused_addr_bits;

    assign unused_addr_bits = ^req_addr[XLEN-1:ADDR_WIDTH+OFS];
    assign req_ready = (state == IDLE);

    always_comb begin
        req_off   = req_addr[OFS-1:0];
        req_size  = 4'd1 << req_funct3[1:0];
        req_legal = 1'b0;
        if (req_rd_wr_bar) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: req_legal = 1'b1;
                3'b011, 3'b110:                         req_legal = IS64;
                default:                                req_legal = 1'b0;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: req_legal = 1'b1;
                3'b011:                 req_legal = IS64;
                default:                req_legal = 1'b0;
            endcase
        end
        req_misaligned = (4'(req_off) & (req_size - 4'd1)) != 4'd0;
        req_split      = (5'(req_off) + 5'(req_size)) > 5'(NB);
        req_fault      = !req_legal || (req_misaligned && !MISALIGN_EN);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = req_fault ? DONE : BEAT0;
            BEAT0:   state_nxt = r_split ? BEAT1 : DONE;
            BEAT1:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_load   <= 1'b1;
            r_funct3 <= 3'b000;
            r_off    <= '0;
            r_w0     <= '0;
            r_wdata  <= '0;
            r_split  <= 1'b0;
            r_fault  <= 1'b0;
            lo_buf   <= '0;
        end else begin
            if (state == IDLE && req_valid) begin
                r_load   <= req_rd_wr_bar;
                r_funct3 <= req_funct3;
                r_off    <= req_off;
                r_w0     <= req_addr[ADDR_WIDTH+OFS-1:OFS];
                r_wdata  <= req_wdata;
                r_split  <= req_split;
                r_fault  <= req_fault;
            end
            // beat-0 read data arrives while beat 1 is on the bus
            if (state == BEAT1) begin
                lo_buf <= mem_rdata;
            end
        end
    end

    logic [3:0]        r_size;
    logic [2*NB-1:0]   be_wide;
    logic [2*XLEN-1:0] wd_wide;

    always_comb begin
        r_size  = 4'd1 << r_funct3[1:0];
        be_wide = ((BE_ONE << r_size) - BE_ONE) << r_off;
        wd_wide = {{XLEN{1'b0}}, r_wdata} << {r_off, 3'b000};
    end

    always_comb begin
        mem_enable    = 1'b0;
        mem_rd_wr_bar = 1'b1;
        mem_addr      = '0;
        mem_be        = '0;
        mem_wdata     = '0;
        if (state == BEAT0 || state == BEAT1) begin
            mem_enable    = 1'b1;
            mem_rd_wr_bar = r_load;
            if (state == BEAT1) begin
                mem_addr = r_w0 + ADDR_WIDTH'(1);
            end else begin
                mem_addr = r_w0;
            end
            if (r_load) begin
                mem_be = '1;
            end else if (state == BEAT1) begin
                mem_be    = be_wide[2*NB-1:NB];
                mem_wdata = wd_wide[2*XLEN-1:XLEN];
            end else begin
                mem_be    = be_wide[NB-1:0];
                mem_wdata = wd_wide[XLEN-1:0];
            end
        end
    end

    logic [XLEN-1:0] ld_lo, ld_hi, ld_shift, ld_data;

    always_comb begin
        ld_lo    = r_split ? lo_buf : mem_rdata;
        ld_hi    = r_split ? mem_rdata : '0;
        ld_shift = XLEN'({ld_hi, ld_lo} >> {r_off, 3'b000});
        case (r_funct3)
            3'b000:  ld_data = XLEN'($signed(ld_shift[7:0]));
            3'b001:  ld_data = XLEN'($signed(ld_shift[15:0]));
            3'b010:  ld_data = XLEN'($signed(ld_shift[31:0]));
            3'b100:  ld_data = XLEN'(ld_shift[7:0]);
            3'b101:  ld_data = XLEN'(ld_shift[15:0]);
            3'b110:  ld_data = XLEN'(ld_shift[31:0]);
            default: ld_data = ld_shift;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_fault <= 1'b0;
        end else begin
            rsp_valid <= (state == DONE);
            if (state == DONE) begin
                rsp_fault <= r_fault;
                rsp_rdata <= (r_fault || !r_load) ? '0 : ld_data;
            end
        end
    end
endmodule

// File: tb/tb_lsu_multicycle.sv
// tb/tb_lsu_multicycle.sv - self-checking bench for lsu_multicycle against a byte-addressed memory model
module tb_lsu_multicycle;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_rd_wr_bar = 1'b1;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_enable, mem_rd_wr_bar;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;

    logic        na_req_ready, na_rsp_valid, na_rsp_fault;
    logic [31:0] na_rsp_rdata;
    logic        na_mem_enable, na_mem_rd_wr_bar;
    logic [8:0]  na_mem_addr;
    logic [3:0]  na_mem_be;
    logic [31:0] na_mem_wdata;
    logic [31:0] na_mem_rdata;
    assign na_mem_rdata = 32'h0;

    always #5 clk = ~clk;

    lsu_multicycle #(.XLEN(32), .ADDR_WIDTH(9), .MISALIGN_EN(1'b1)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd_wr_bar(req_rd_wr_bar), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_fault(rsp_fault), .mem_enable(mem_enable), .mem_rd_wr_bar(mem_rd_wr_bar),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    lsu_multicycle #(.XLEN(32), .ADDR_WIDTH(9), .MISALIGN_EN(1'b0)) u_na (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(na_req_ready),
        .req_rd_wr_bar(req_rd_wr_bar), .req_funct3(req_funct3), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(na_rsp_valid), .rsp_rdata(na_rsp_rdata),
        .rsp_fault(na_rsp_fault), .mem_enable(na_mem_enable), .mem_rd_wr_bar(na_mem_rd_wr_bar),
        .mem_addr(na_mem_addr), .mem_be(na_mem_be), .mem_wdata(na_mem_wdata), .mem_rdata(na_mem_rdata)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int idle_bad = 0;

    typedef struct {
        logic [8:0]  addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rd;
    } beat_t;
    beat_t beats[$];

    logic [31:0] tmem [0:511];
    logic [7:0]  ref_mem [0:2047];
    logic        poke_en = 1'b0;
    logic [8:0]  poke_addr = 9'h0;
    logic [31:0] poke_data = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (poke_en) begin
            tmem[poke_addr] <= poke_data;
        end else if (mem_enable) begin
            if (mem_rd_wr_bar) begin
                mem_rdata <= tmem[mem_addr];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) tmem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always @(negedge clk) begin
        if (mem_enable === 1'b1) begin
            beats.push_back('{addr: mem_addr, be: mem_be, wdata: mem_wdata, rd: mem_rd_wr_bar});
        end else if (mem_rd_wr_bar !== 1'b1 || mem_addr !== 9'h0 || mem_be !== 4'h0 || mem_wdata !== 32'h0) begin
            idle_bad <= idle_bad + 1;
        end
        if (na_mem_enable !== 1'b1 && (na_mem_rd_wr_bar !== 1'b1 || na_mem_addr !== 9'h0 ||
                                       na_mem_be !== 4'h0 || na_mem_wdata !== 32'h0))
            idle_bad <= idle_bad + 1;
    end

    function automatic int ref_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic logic ref_legal(input logic ld, input logic [2:0] f3);
        if (ld) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] v = 32'h0;
        int s = ref_size(f3);
        for (int i = 0; i < s; i++) v[8*i +: 8] = ref_mem[int'((a + 32'(i)) & 32'h7FF)];
        if (!f3[2] && s < 4 && v[8*s-1]) v = v | ~((32'd1 << (8*s)) - 32'd1);
        return v;
    endfunction

    task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        for (int i = 0; i < ref_size(f3); i++) ref_mem[int'((a + 32'(i)) & 32'h7FF)] = wd[8*i +: 8];
    endtask

    task automatic poke(input int w, input logic [31:0] v);
        poke_en = 1'b1; poke_addr = 9'(w); poke_data = v;
        for (int b = 0; b < 4; b++) ref_mem[w*4 + b] = v[8*b +: 8];
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic issue(input logic ld, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic flt, output int lat);
        int guard = 0;
        while (req_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
        beats.delete();
        req_valid = 1'b1; req_rd_wr_bar = ld; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0; req_rd_wr_bar = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        lat = -1; rd = 32'hx; flt = 1'bx;
        for (int n = 1; n <= 10; n++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1) begin lat = n; rd = rsp_rdata; flt = rsp_fault; break; end
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
        total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        total++; if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        total++; if (rsp_fault !== 1'b0) begin bad++; $display("FAIL reset_rsp_fault got=%b want=0", rsp_fault); end
        total++; if (mem_enable !== 1'b0) begin bad++; $display("FAIL reset_mem_enable got=%b want=0", mem_enable); end
        total++; if (mem_rd_wr_bar !== 1'b1) begin bad++; $display("FAIL reset_mem_rd_wr_bar got=%b want=1", mem_rd_wr_bar); end
        total++;
        if ({mem_addr, mem_be, mem_wdata} !== 45'h0) begin
            bad++; $display("FAIL reset_mem_bus got addr=%h be=%h wdata=%h want 0", mem_addr, mem_be, mem_wdata);
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd; logic flt; int lat;
        logic [2:0]  ext_f3 [3] = '{3'b000, 3'b100, 3'b001};
        logic [31:0] ext_a  [3] = '{32'h13, 32'h13, 32'h12};
        logic [31:0] ext_e  [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF};

        poke(4, 32'hDEADBEEF);
        issue(1'b1, 3'b010, 32'h10, 32'h0, rd, flt, lat);
        total++; if (rd !== 32'hDEADBEEF || flt !== 1'b0) begin bad++; $display("FAIL lw_aligned got=%h/%b want=deadbeef/0", rd, flt); end
        total++; if (lat !== 3) begin bad++; $display("FAIL lw_aligned_latency got=%0d want=3", lat); end
        total++;
        if (beats.size() !== 1 || beats[0].addr !== 9'd4 || beats[0].be !== 4'hF || beats[0].rd !== 1'b1) begin
            bad++; $display("FAIL lw_aligned_beat got count=%0d want 1 beat addr=4 be=f", beats.size());
        end

        poke(4, 32'h80FF0000);
        for (int i = 0; i < 3; i++) begin
            issue(1'b1, ext_f3[i], ext_a[i], 32'h0, rd, flt, lat);
            total++;
            if (rd !== ext_e[i] || lat !== 3) begin
                bad++; $display("FAIL extend_%0d got=%h lat=%0d want=%h lat=3", i, rd, lat, ext_e[i]);
            end
        end

        poke(3, 32'hAABBCCDD);
        poke(4, 32'h11223344);
        issue(1'b1, 3'b010, 32'h0E, 32'h0, rd, flt, lat);
        total++; if (rd !== 32'h3344AABB || lat !== 4) begin bad++; $display("FAIL lw_split got=%h lat=%0d want=3344aabb lat=4", rd, lat); end
        total++;
        if (beats.size() !== 2 || beats[0].addr !== 9'd3 || beats[1].addr !== 9'd4) begin
            bad++; $display("FAIL lw_split_beats got count=%0d want 2 beats at 3,4", beats.size());
        end

        issue(1'b0, 3'b010, 32'h0E, 32'h12345678, rd, flt, lat);
        ref_store(3'b010, 32'h0E, 32'h12345678);
        total++; if (rd !== 32'h0 || flt !== 1'b0 || lat !== 4) begin bad++; $display("FAIL sw_split_rsp got=%h/%b lat=%0d want=0/0 lat=4", rd, flt, lat); end
        total++;
        if (beats.size() !== 2) begin
            bad++; $display("FAIL sw_split_count got=%0d want=2", beats.size());
        end else if (beats[0].addr !== 9'd3 || beats[0].be !== 4'hC || beats[0].wdata !== 32'h56780000 || beats[0].rd !== 1'b0 ||
                     beats[1].addr !== 9'd4 || beats[1].be !== 4'h3 || beats[1].wdata !== 32'h00001234 || beats[1].rd !== 1'b0) begin
            bad++;
            $display("FAIL sw_split_lanes got %h/%h/%h %h/%h/%h want 003/c/56780000 004/3/00001234",
                     beats[0].addr, beats[0].be, beats[0].wdata, beats[1].addr, beats[1].be, beats[1].wdata);
        end
        issue(1'b1, 3'b010, 32'h0C, 32'h0, rd, flt, lat);
        total++; if (rd !== 32'h5678CCDD) begin bad++; $display("FAIL sw_split_readback got=%h want=5678ccdd", rd); end
    endtask

    task automatic test_fault();
        logic [31:0] rd; logic flt; int lat;
        logic       f_ld [3] = '{1'b1, 1'b1, 1'b0};
        logic [2:0] f_f3 [3] = '{3'b011, 3'b111, 3'b100};
        for (int i = 0; i < 3; i++) begin
            issue(f_ld[i], f_f3[i], 32'h10, 32'hFFFFFFFF, rd, flt, lat);
            total++;
            if (flt !== 1'b1 || rd !== 32'h0 || lat !== 2 || beats.size() !== 0) begin
                bad++; $display("FAIL fault_%0d got flt=%b rd=%h lat=%0d beats=%0d want 1/0/2/0", i, flt, rd, lat, beats.size());
            end
        end
    endtask

    task automatic test_misalign_disabled();
        logic [31:0] m_a  [2] = '{32'h01, 32'h10};
        logic [2:0]  m_f3 [2] = '{3'b001, 3'b010};
        logic        m_ef [2] = '{1'b1, 1'b0};
        int          m_el [2] = '{2, 3};
        for (int i = 0; i < 2; i++) begin
            int na_lat = -1; logic na_flt = 1'bx; logic [31:0] na_rd = 32'hx; int na_beats = 0;
            int guard = 0;
            while ((req_ready !== 1'b1 || na_req_ready !== 1'b1) && guard < 20) begin @(negedge clk); guard++; end
            req_valid = 1'b1; req_rd_wr_bar = 1'b1; req_funct3 = m_f3[i]; req_addr = m_a[i];
            @(posedge clk); #1;
            req_valid = 1'b0;
            for (int n = 1; n <= 6; n++) begin
                @(negedge clk);
                if (na_mem_enable === 1'b1) na_beats++;
                if (na_rsp_valid === 1'b1 && na_lat < 0) begin na_lat = n; na_flt = na_rsp_fault; na_rd = na_rsp_rdata; end
            end
            total++;
            if (na_lat !== m_el[i] || na_flt !== m_ef[i] || na_rd !== 32'h0 || (m_ef[i] && na_beats != 0)) begin
                bad++; $display("FAIL misalign_off_%0d got lat=%0d flt=%b rd=%h beats=%0d want lat=%0d flt=%b",
                                i, na_lat, na_flt, na_rd, na_beats, m_el[i], m_ef[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic flt; int lat;
        for (int it = 0; it < 150; it++) begin
            logic        ld = 1'($urandom);
            logic [2:0]  f3 = 3'($urandom);
            logic [31:0] a  = (it % 5 == 0) ? $urandom : $urandom_range(0, 2047);
            logic [31:0] wd = $urandom;
            logic        e_flt = !ref_legal(ld, f3);
            logic        e_split = ({30'h0, a[1:0]} + 32'(ref_size(f3))) > 32'd4;
            logic [31:0] e_rd = (!e_flt && ld) ? ref_load(f3, a) : 32'h0;
            int          e_lat = e_flt ? 2 : (e_split ? 4 : 3);
            int          e_beats = e_flt ? 0 : (e_split ? 2 : 1);
            issue(ld, f3, a, wd, rd, flt, lat);
            if (!e_flt && !ld) ref_store(f3, a, wd);
            total++;
            if (rd !== e_rd || flt !== e_flt || lat !== e_lat) begin
                bad++; $display("FAIL rand_rsp it=%0d ld=%b f3=%0d a=%h got %h/%b/%0d want %h/%b/%0d",
                                it, ld, f3, a, rd, flt, lat, e_rd, e_flt, e_lat);
            end
            total++;
            if (beats.size() !== e_beats || (e_beats > 0 && (beats[0].addr !== a[10:2] || beats[0].rd !== ld))) begin
                bad++; $display("FAIL rand_beats it=%0d got count=%0d want=%0d first addr %h", it, beats.size(), e_beats, a[10:2]);
            end
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b0 || rsp_rdata !== rd) begin
                bad++; $display("FAIL rand_pulse it=%0d got valid=%b rdata=%h want valid=0 held %h", it, rsp_valid, rsp_rdata, rd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic flt; int lat;
        int c0;
        @(negedge clk);
        c0 = cyc;
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a = {21'h0, 9'($urandom), 2'b00};
            logic [31:0] e = ref_load(3'b010, a);
            issue(1'b1, 3'b010, a, 32'h0, rd, flt, lat);
            total++;
            if (rd !== e || lat !== 3) begin bad++; $display("FAIL b2b_%0d got=%h lat=%0d want=%h lat=3", i, rd, lat, e); end
        end
        total++;
        if (cyc - c0 !== 12) begin bad++; $display("FAIL b2b_throughput got=%0d cycles want=12", cyc - c0); end
    endtask

    task automatic test_wrap_reset();
        logic [31:0] rd; logic flt; int lat; int seen = 0;
        logic [31:0] e = ref_load(3'b010, 32'h7FE);
        issue(1'b1, 3'b010, 32'h7FE, 32'h0, rd, flt, lat);
        total++;
        if (beats.size() !== 2 || beats[0].addr !== 9'h1FF || beats[1].addr !== 9'h000 || rd !== e || lat !== 4) begin
            bad++; $display("FAIL wrap got count=%0d rd=%h lat=%0d want 2 beats 1ff,000 rd=%h lat=4", beats.size(), rd, lat, e);
        end

        req_valid = 1'b1; req_rd_wr_bar = 1'b1; req_funct3 = 3'b010; req_addr = 32'h7FE;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        total++;
        if (mem_enable !== 1'b1 || mem_addr !== 9'h000) begin
            bad++; $display("FAIL reset_pre_beat1 got en=%b addr=%h want 1/000", mem_enable, mem_addr);
        end
        reset = 1'b0;
        #1;
        total++;
        if (mem_enable !== 1'b0 || req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            bad++; $display("FAIL reset_abort got en=%b ready=%b valid=%b want 0/1/0", mem_enable, req_ready, rsp_valid);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (rsp_valid === 1'b1 || mem_enable === 1'b1) seen++;
        end
        total++;
        if (seen !== 0 || req_ready !== 1'b1 || rsp_rdata !== 32'h0) begin
            bad++; $display("FAIL reset_no_resume got activity=%0d ready=%b rdata=%h want 0/1/0", seen, req_ready, rsp_rdata);
        end
    endtask

    task automatic test_memory_image();
        for (int w = 0; w < 512; w++) begin
            logic [31:0] e = {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]};
            total++;
            if (tmem[w] !== e) begin bad++; $display("FAIL mem_word_%0d got=%h want=%h", w, tmem[w], e); end
        end
        total++;
        if (idle_bad !== 0) begin bad++; $display("FAIL idle_bus got=%0d non-reset idle cycles want=0", idle_bad); end
    endtask

    initial begin
        reset = 1'b1;
        #2 reset = 1'b0;
        test_reset();
        for (int w = 0; w < 512; w++) poke(w, $urandom);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        test_directed();
        test_fault();
        test_misalign_disabled();
        test_random();
        test_back_to_back();
        test_wrap_reset();
        test_memory_image();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
